// File: rtl/parity_pipe_check.sv
// parity_pipe_check
//   Single-stage parity checker with a valid/ready handshake on both sides.
//   Each accepted word is loaded into a one-deep output register holding its
//   parity (even/odd) and a check result (err) against the received parity
//   bit. Two statistics counters track accepted words and erroring words.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid=1 and ready=1. A source
//   holding valid=1 while ready=0 must keep its payload stable; nothing is
//   consumed. in_ready = (~out_valid | out_ready) & ~reset, so the stage
//   accepts when it is empty or being drained on the same edge, giving one
//   word per cycle of throughput.
//
// Parameters:
//   DATA_W   data word width in bits (2..64)
//   ODD_MODE 0 = even parity over data+parity bit, 1 = odd parity
//   CNT_W    width of word_count and err_count
//
// Ports:
//   clk        clock, all state changes on rising edge
//   reset      synchronous active-high reset
//   in_valid   input word present
//   data_in    input data word
//   parity_in  received parity bit for data_in
//   in_ready   stage can accept a word this cycle
//   out_valid  result register holds a result
//   out_ready  consumer takes the result this cycle
//   even       data had an even number of ones
//   odd        data had an odd number of ones
//   err        word failed the parity check
//   clr_count  synchronous clear of both counters
//   word_count accepted words (wraps)
//   err_count  accepted words with err=1 (saturates)
module parity_pipe_check #(
  parameter int DATA_W   = 9,
  parameter int ODD_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              even,
  output logic              odd,
  output logic              err,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic ODD_BIT = (ODD_MODE != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic             even_q, even_d;
  logic             odd_q, odd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic accept;
  logic odd_calc;
  logic err_calc;

  assign in_ready = (~out_valid_q | out_ready) & ~reset;
  assign accept   = in_valid & in_ready;

  // Parity of the data alone; the check folds in the received parity bit and
  // flags a word whose overall parity does not match the system parity.
  assign odd_calc = ^data_in;
  assign err_calc = ((odd_calc ^ parity_in) != ODD_BIT);

  // Output register next state. A drain without a new word only clears
  // out_valid; the last result bits are kept.
  always_comb begin
    out_valid_d = out_valid_q;
    even_d      = even_q;
    odd_d       = odd_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      even_d      = ~odd_calc;
      odd_d       = odd_calc;
      err_d       = err_calc;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Counters. A clear on the same edge as an accept still counts that word.
  always_comb begin
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    if (clr_count) begin
      word_count_d = accept ? CNT_ONE : '0;
      err_count_d  = (accept && err_calc) ? CNT_ONE : '0;
    end else if (accept) begin
      word_count_d = word_count_q + CNT_ONE;
      if (err_calc && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      even_q       <= 1'b1;
      odd_q        <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      even_q       <= even_d;
      odd_q        <= odd_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign even       = even_q;
  assign odd        = odd_q;
  assign err        = err_q;
  assign word_count = word_count_q;
  assign err_count  = err_count_q;

endmodule

// File: doc/parity_pipe_check.md
PARITY_PIPE_CHECK -- requirements
Module: parity_pipe_check

Interface
REQ-001 Parameter DATA_W, default 9, SHALL set the data word width in bits (legal 2..64).
REQ-002 Parameter ODD_MODE, default 0, SHALL select the system parity: 0 = even parity across data plus parity bit, 1 = odd parity.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of both statistics counters.
REQ-004 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL flag that data_in/parity_in hold a word.
REQ-007 data_in  input  DATA_W  SHALL carry the data word.
REQ-008 parity_in  input  1  SHALL carry the received parity bit for data_in.
REQ-009 in_ready  output  1  SHALL flag that the block accepts a word this cycle.
REQ-010 out_valid  output  1  SHALL flag that even/odd/err hold a result.
REQ-011 out_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-012 even  output  1  SHALL be 1 when data_in has an even number of 1s.
REQ-013 odd  output  1  SHALL be 1 when data_in has an odd number of 1s.
REQ-014 err  output  1  SHALL be 1 when the word failed the parity check.
REQ-015 clr_count  input  1  SHALL synchronously clear both counters.
REQ-016 word_count  output  CNT_W  SHALL count accepted words.
REQ-017 err_count  output  CNT_W  SHALL count accepted words with err=1.

Function
REQ-018 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-019 in_ready SHALL equal (~out_valid | out_ready) & ~reset, combinationally.
REQ-020 On accept, the output register SHALL load on the same edge: odd = XOR of all data_in bits, even = ~odd, err = (odd ^ parity_in) != ODD_MODE; out_valid SHALL be 1 the next cycle (latency 1).
REQ-021 When out_valid=1 and out_ready=1 with no accept, out_valid SHALL clear to 0; even/odd/err SHALL hold their last values.
REQ-022 When out_valid=1 and out_ready=0, even/odd/err/out_valid SHALL remain stable and no word SHALL be accepted.
REQ-023 Simultaneous out_ready=1 and accept SHALL replace the result with the new word, out_valid staying 1 (full throughput, one word per cycle).
REQ-024 word_count SHALL increment by 1 per accept and wrap from all-ones to 0.
REQ-025 err_count SHALL increment by 1 per accept with computed err=1 and saturate at all-ones.
REQ-026 clr_count=1 SHALL set both counters to 0, except that an accept on the same edge SHALL leave word_count=1 and err_count=1 if that word errs, else 0.
REQ-027 Counters SHALL update on the same edge as the output register load.
REQ-028 in_valid=1 while in_ready=0 SHALL have no effect; the source holds the word.

Reset
REQ-029 reset=1 SHALL on the next edge force out_valid=0, even=1, odd=0, err=0, word_count=0, err_count=0, overriding accept and clr_count.
REQ-030 While reset=1, in_ready SHALL be 0; a word presented mid-reset SHALL be discarded, and a pending unconsumed result SHALL be dropped.
REQ-031 First accept SHALL be possible on the first edge after reset deasserts.

Verification (DATA_W=9, CNT_W=16)
REQ-032 Assert reset 2 cycles -> out_valid=0, even=1, odd=0, err=0, counts 0, in_ready=0 during reset, 1 after.
REQ-033 ODD_MODE=0, data_in=9'h1FF, parity_in=1, out_ready=1 -> next cycle out_valid=1, odd=1, even=0, err=0, word_count=1, err_count=0.
REQ-034 ODD_MODE=0, data_in=9'h001, parity_in=0 -> odd=1, err=1, err_count=1; same word with ODD_MODE=1 -> err=0.
REQ-035 Accept 9'h003 then hold out_ready=0 for 3 cycles with in_valid=1, data 9'h007 -> in_ready=0, even=1 stable 3 cycles; on out_ready=1 word 9'h007 accepted, next cycle odd=1.
REQ-036 Stream 65540 erroring words back-to-back -> err_count=16'hFFFF, word_count=16'h0004; then clr_count=1 with an erroring accept -> err_count=1, word_count=1.
REQ-037 Assert reset while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, counts 0, held result never delivered.
